// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the synth datapath: divider FSM states,
// iteration count and quotient saturation limits.
package arith_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } div_state_e;

  localparam int          DIV_ITERS = 24;
  localparam logic [23:0] QUOT_MAX  = 24'h7FFFFF;
  localparam logic [23:0] QUOT_MIN  = 24'h800000;

endpackage

// File: rtl/div.sv
// Signed 24/16 restoring shift-subtract divider, one quotient bit per clock.
// Optional round-to-nearest (half away from zero) quotient when DIV_ROUND_EN is defined.
module div
  import arith_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [23:0] dividend_i,
  input  logic [15:0] divisor_i,
  output logic        ready_o,
  output logic [23:0] quot_o,
  output logic [15:0] rem_o,
  output logic        dz_o
);

  // Handshake: a start_i pulse is accepted only in IDLE (including while ready_o=1);
  // ready_o stays high until the next accepted start and drops combinationally with it.
  div_state_e  state_q;
  logic [23:0] num_q;
  logic [15:0] den_q;
  logic [15:0] prem_q;
  logic [4:0]  iter_q;
  logic        done_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        dz_q;

  logic [16:0] t;
  logic        ge;
  logic [15:0] diff;
  logic [15:0] prem_d;

  always_comb begin
    t      = {prem_q, num_q[23]};
    ge     = (t >= {1'b0, den_q});
    // When ge holds the true difference is below den, so 16 bits are exact.
    diff   = t[15:0] - den_q;
    prem_d = ge ? diff : t[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      num_q   <= '0;
      den_q   <= '0;
      prem_q  <= '0;
      iter_q  <= '0;
      done_q  <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ITER;
            neg_q_q <= dividend_i[23] ^ divisor_i[15];
            neg_r_q <= dividend_i[23];
            num_q   <= dividend_i[23] ? (~dividend_i + 24'd1) : dividend_i;
            den_q   <= divisor_i[15] ? (~divisor_i + 16'd1) : divisor_i;
            prem_q  <= '0;
            iter_q  <= '0;
            done_q  <= 1'b0;
            dz_q    <= (divisor_i == 16'd0);
          end
        end
        ITER: begin
          prem_q <= prem_d;
          num_q  <= {num_q[22:0], ge};
          iter_q <= iter_q + 5'd1;
          if (iter_q == 5'(DIV_ITERS - 1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = done_q & ~start_i;
  assign dz_o    = dz_q;

`ifdef DIV_ROUND_EN
  logic        rnd;
  logic [24:0] qr;
  logic [24:0] qr_neg;
  always_comb begin
    // den_q != 0 keeps the reset state (all zero) from rounding up to 1.
    rnd    = ({prem_q, 1'b0} >= {1'b0, den_q}) && (den_q != 16'd0);
    qr     = {1'b0, num_q} + {24'd0, rnd};
    qr_neg = 25'd0 - qr;
  end
`endif

  always_comb begin
    quot_o = '0;
    rem_o  = neg_r_q ? (~prem_q + 16'd1) : prem_q;
    if (dz_q) begin
      quot_o = neg_r_q ? QUOT_MIN : QUOT_MAX;
      rem_o  = '0;
    end else begin
`ifdef DIV_ROUND_EN
      if (neg_q_q) quot_o = (qr > 25'h0800000) ? QUOT_MIN : qr_neg[23:0];
      else         quot_o = (qr > 25'h07FFFFF) ? QUOT_MAX : qr[23:0];
`else
      // Only -2^23 / -1 yields a magnitude of 2^23 with a positive sign.
      if (neg_q_q)       quot_o = ~num_q + 24'd1;
      else if (num_q[23]) quot_o = QUOT_MAX;
      else               quot_o = num_q;
`endif
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for the div block: signed cases, overflow, divide by zero,
// handshake corner cases and mid-operation reset; DIV_ROUND_EN selects expectations.
module tb_div;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [23:0] dividend_i;
  logic [15:0] divisor_i;
  logic        ready_o;
  logic [23:0] quot_o;
  logic [15:0] rem_o;
  logic        dz_o;

  int total;
  int bad;

  div u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .ready_o    (ready_o),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .dz_o       (dz_o)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge. Drives a start pulse, then checks latency and ready.
  task automatic run_op(input string tag, input logic [23:0] a, input logic [15:0] b);
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
    #1;
    check({tag, "_rdy_drop"}, 32'(ready_o), 32'd0);
    @(negedge clk_i);
    start_i    = 1'b0;
    dividend_i = $urandom_range(0, 24'hFFFFFF);
    divisor_i  = $urandom_range(0, 16'hFFFF);
    repeat (23) @(negedge clk_i);
    check({tag, "_rdy_early"}, 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check({tag, "_rdy"}, 32'(ready_o), 32'd1);
  endtask

  task automatic check_res(input string tag, input int q, input int r, input logic dz);
    check({tag, "_q"}, {8'd0, quot_o}, {8'd0, 24'(q)});
    check({tag, "_r"}, {16'd0, rem_o}, {16'd0, 16'(r)});
    check({tag, "_dz"}, 32'(dz_o), 32'(dz));
  endtask

  // Expected quotients that differ between truncating and rounding builds.
`ifdef DIV_ROUND_EN
  localparam int Q1000_7 = 143;
  localparam int Q10_4   = 3;
`else
  localparam int Q1000_7 = 142;
  localparam int Q10_4   = 2;
`endif

  initial begin
    total      = 0;
    bad        = 0;
    rst_ni     = 1'b0;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    repeat (3) @(negedge clk_i);
    check("reset_rdy", 32'(ready_o), 32'd0);
    check_res("reset", 0, 0, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op("p1000_7", 24'd1000, 16'd7);
    check_res("p1000_7", Q1000_7, 6, 1'b0);
    // Result must hold across idle cycles.
    repeat (5) @(negedge clk_i);
    check("hold_rdy", 32'(ready_o), 32'd1);
    check_res("hold", Q1000_7, 6, 1'b0);

    run_op("n1000_7", 24'(-1000), 16'd7);
    check_res("n1000_7", -Q1000_7, -6, 1'b0);
    run_op("p1000_n7", 24'd1000, 16'(-7));
    check_res("p1000_n7", -Q1000_7, 6, 1'b0);

    run_op("ovf", 24'h800000, 16'hFFFF);
    check_res("ovf", 32'h7FFFFF, 0, 1'b0);
    run_op("max_n1", 24'd8388607, 16'hFFFF);
    check_res("max_n1", -8388607, 0, 1'b0);
    run_op("min_p1", 24'h800000, 16'd1);
    check_res("min_p1", 32'h800000, 0, 1'b0);

    run_op("dz_pos", 24'd1234, 16'd0);
    check_res("dz_pos", 32'h7FFFFF, 0, 1'b1);
    run_op("dz_neg", 24'(-5), 16'd0);
    check_res("dz_neg", 32'h800000, 0, 1'b1);

    run_op("p10_4", 24'd10, 16'd4);
    check_res("p10_4", Q10_4, 2, 1'b0);
    run_op("n10_4", 24'(-10), 16'd4);
    check_res("n10_4", -Q10_4, -2, 1'b0);
    run_op("p9_4", 24'd9, 16'd4);
    check_res("p9_4", 2, 1, 1'b0);
    run_op("min_max_div", 24'h800000, 16'h8000);
    check_res("min_max_div", 256, 0, 1'b0);

    // start mid-ITER must be ignored
    start_i    = 1'b1;
    dividend_i = 24'd100;
    divisor_i  = 16'd10;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = 24'd50;
    divisor_i  = 16'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (17) @(negedge clk_i);
    check("ign_rdy_early", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    check("ign_rdy", 32'(ready_o), 32'd1);
    check_res("ign", 10, 0, 1'b0);

    // back-to-back start on the ready cycle; run_op checks the same-cycle drop
    run_op("b2b", 24'd77, 16'd5);
    check_res("b2b", 15, 2, 1'b0);

    // reset at iteration 10 aborts the operation
    start_i    = 1'b1;
    dividend_i = 24'd5000;
    divisor_i  = 16'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_rdy", 32'(ready_o), 32'd0);
    check_res("rst_mid", 0, 0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (30) @(negedge clk_i);
    check("rst_after_rdy", 32'(ready_o), 32'd0);
    check("rst_after_q", {8'd0, quot_o}, 32'd0);

    // divider still works after the abort
    run_op("post_rst", 24'd1000, 16'd7);
    check_res("post_rst", Q1000_7, 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
